// File: rtl/mod_arith_pkg.sv
// Shared constants for the modular add/subtract datapath: mode encoding,
// default operand width and the default NTT prime used by benches.
package mod_arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int          DEFAULT_W = 28;
    localparam logic [27:0] DEFAULT_Q = 28'd268369921;  // 2^28 - 2^16 + 1

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Beat-level valid/ready bus of mod_addsub_pipe: operand side and result side.
interface mod_addsub_pipe_if #(
    parameter int W     = 28,
    parameter int LANES = 4,
    parameter int TAG_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic [W-1:0]       in_q;
    logic [LANES*W-1:0] in_x;
    logic [LANES*W-1:0] in_y;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_z;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_mode, in_q, in_x, in_y, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_q, in_x, in_y, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag
    );
endinterface

// File: rtl/mod_addsub_lane.sv
// One lane of the modular adder/subtractor: stage 1 forms x+y or x+(q-y) in
// W+1 bits, stage 2 conditionally subtracts q. Both stages hold when adv is low.
module mod_addsub_lane
    import mod_arith_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    input  logic         mode,
    input  logic [W-1:0] q,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] z
);

    logic [W:0]   s_p1_d, s_p1_q;
    logic [W-1:0] q_p1_d, q_p1_q;
    logic [W-1:0] z_p2_d, z_p2_q;
    logic [W:0]   q_minus_y;

    function automatic logic [W-1:0] cond_sub(input logic [W:0] s, input logic [W-1:0] m);
        logic [W:0] d;
        d = s - {1'b0, m};
        return (s >= {1'b0, m}) ? d[W-1:0] : s[W-1:0];
    endfunction

    // stage 1: unreduced sum, W+1 bits so nothing wraps before the compare
    always_comb begin
        q_minus_y = {1'b0, q} - {1'b0, y};
        s_p1_d    = s_p1_q;
        q_p1_d    = q_p1_q;
        if (adv) begin
            s_p1_d = (mode == MODE_SUB) ? ({1'b0, x} + q_minus_y) : ({1'b0, x} + {1'b0, y});
            q_p1_d = q;
        end
    end

    // stage 2: single conditional subtraction brings the sum into [0, q)
    always_comb begin
        z_p2_d = z_p2_q;
        if (adv) begin
            z_p2_d = cond_sub(s_p1_q, q_p1_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p1_q <= '0;
            q_p1_q <= '0;
            z_p2_q <= '0;
        end else begin
            s_p1_q <= s_p1_d;
            q_p1_q <= q_p1_d;
            z_p2_q <= z_p2_d;
        end
    end

    assign z = z_p2_q;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage multi-lane modular add/subtract with valid/ready flow control.
// Optional sticky operand range check under MODADDSUB_RANGE_CHECK_EN.
module mod_addsub_pipe
    import mod_arith_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MODADDSUB_RANGE_CHECK_EN
    output logic range_err,
`endif
    mod_addsub_pipe_if.slave bus
);

    logic               adv;
    logic               vld_p1_d, vld_p1_q;
    logic               vld_p2_d, vld_p2_q;
    logic [TAG_W-1:0]   tag_p1_d, tag_p1_q;
    logic [TAG_W-1:0]   tag_p2_d, tag_p2_q;
    logic [LANES*W-1:0] z_all;

    // A single enable moves the whole pipe; bubbles in stage 1 are not squeezed out.
    assign adv          = !vld_p2_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        tag_p1_d = tag_p1_q;
        tag_p2_d = tag_p2_q;
        if (adv) begin
            vld_p1_d = bus.in_valid;
            tag_p1_d = bus.in_tag;
            vld_p2_d = vld_p1_q;
            tag_p2_d = tag_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            tag_p1_q <= '0;
            tag_p2_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            tag_p1_q <= tag_p1_d;
            tag_p2_q <= tag_p2_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_addsub_lane #(.W(W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .mode  (bus.in_mode),
            .q     (bus.in_q),
            .x     (bus.in_x[i*W +: W]),
            .y     (bus.in_y[i*W +: W]),
            .z     (z_all[i*W +: W])
        );
    end

    assign bus.out_valid = vld_p2_q;
    assign bus.out_z     = z_all;
    assign bus.out_tag   = tag_p2_q;

`ifdef MODADDSUB_RANGE_CHECK_EN
    logic range_hit;
    logic range_err_d, range_err_q;

    always_comb begin
        range_hit = (bus.in_q < W'(2));
        for (int i = 0; i < LANES; i++) begin
            if ((bus.in_x[i*W +: W] >= bus.in_q) || (bus.in_y[i*W +: W] >= bus.in_q)) begin
                range_hit = 1'b1;
            end
        end
        range_err_d = range_err_q || (range_hit && bus.in_valid && adv);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe (W=28, LANES=4); range_err checks
// are compiled in when MODADDSUB_RANGE_CHECK_EN is defined.
module tb_mod_addsub_pipe;
    import mod_arith_pkg::*;

    localparam int W     = 28;
    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam logic [W-1:0] Q = DEFAULT_Q;

    typedef struct {
        logic [LANES*W-1:0] z;
        logic [TAG_W-1:0]   tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    sb_t  sb[$];

`ifdef MODADDSUB_RANGE_CHECK_EN
    logic range_err;
`endif

    mod_addsub_pipe_if #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) bus ();

    mod_addsub_pipe #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MODADDSUB_RANGE_CHECK_EN
        .range_err (range_err),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [LANES*W-1:0] pk(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic sb_t model();
        sb_t e;
        longint unsigned xv, yv, qv, zv;
        qv = 64'(bus.in_q);
        for (int i = 0; i < LANES; i++) begin
            xv = 64'(bus.in_x[i*W +: W]);
            yv = 64'(bus.in_y[i*W +: W]);
            zv = bus.in_mode ? ((xv + qv - yv) % qv) : ((xv + yv) % qv);
            e.z[i*W +: W] = zv[W-1:0];
        end
        e.tag = bus.in_tag;
        return e;
    endfunction

    // retire results first, then record the beat about to be accepted on the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 128'(bus.out_tag), 128'hDEAD);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_z", 128'(bus.out_z), 128'(e.z));
                    chk("sb_tag", 128'(bus.out_tag), 128'(e.tag));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model());
        end
    end

    task automatic send(input logic m, input logic [W-1:0] q, input logic [LANES*W-1:0] x,
                        input logic [LANES*W-1:0] y, input logic [TAG_W-1:0] t);
        int k;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_q     = q;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_tag   = t;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("send_timeout", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t;
        logic [W-1:0] qv;
        logic [LANES*W-1:0] xv, yv;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = MODE_ADD;
        bus.in_q      = Q;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_z", 128'(bus.out_z), 128'd0);
        chk("rst_out_tag", 128'(bus.out_tag), 128'd0);
`ifdef MODADDSUB_RANGE_CHECK_EN
        chk("rst_range_err", 128'(range_err), 128'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

        // add with wrap, latency exactly 2
        send(MODE_ADD, Q, pk(28'd268369920, 1, 1, 1), pk(5, 2, 2, 2), 8'h01);
        chk("add_lat1_valid", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;
        chk("add_lat2_valid", 128'(bus.out_valid), 128'd1);
        chk("add_wrap_z", 128'(bus.out_z), 128'(pk(4, 3, 3, 3)));
        chk("add_tag", 128'(bus.out_tag), 128'h01);

        // subtract edge cases incl. y=0 (s = x + q)
        send(MODE_SUB, Q, pk(3, 7, 9, 0), pk(7, 7, 0, 0), 8'h02);
        @(posedge clk); #1;
        chk("sub_valid", 128'(bus.out_valid), 128'd1);
        chk("sub_edge_z", 128'(bus.out_z), 128'(pk(28'd268369917, 0, 9, 0)));
        repeat (3) @(posedge clk);
        #1;

        // mixed moduli and modes at full rate
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            qv = (i % 2 == 1) ? 28'd17 : Q;
            xv[0 +: W] = qv - 1;
            yv[0 +: W] = qv - 1;
            for (int l = 1; l < LANES; l++) begin
                xv[l*W +: W] = W'($urandom_range(32'(qv) - 1, 0));
                yv[l*W +: W] = W'($urandom_range(32'(qv) - 1, 0));
            end
            send(logic'((i / 2) % 2), qv, xv, yv, TAG_W'(8'h10 + i));
        end
        chk("mixed_throughput", 128'(cyc - c0), 128'd8);
        repeat (3) @(posedge clk);
        #1;

        // backpressure: out_ready low for cycles 3..6 of the stream
        t = 0;
        for (int c = 0; c < 40 && (t < 8 || sb.size() > 0); c++) begin
            bus.out_ready = !(c >= 3 && c <= 6);
            if (t < 8) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = MODE_ADD;
                bus.in_q     = Q;
                bus.in_x     = pk(W'(t), W'(t + 100), Q - 1, 0);
                bus.in_y     = pk(W'(t + 1), 5, W'(t + 1), 0);
                bus.in_tag   = TAG_W'(t);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
                chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
                chk("bp_tag_frozen", 128'(bus.out_tag), 128'(sb[0].tag));
                chk("bp_z_frozen", 128'(bus.out_z), 128'(sb[0].z));
            end
            if (bus.in_valid && bus.in_ready) t++;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_all_sent", 128'(t), 128'd8);
        chk("bp_drained", 128'(sb.size()), 128'd0);

        // reset with two beats in flight
        send(MODE_ADD, Q, pk(1, 2, 3, 4), pk(1, 1, 1, 1), 8'hA5);
        send(MODE_SUB, Q, pk(1, 2, 3, 4), pk(2, 3, 4, 5), 8'h5A);
        chk("mid_pre_valid", 128'(bus.out_valid), 128'd1);
        chk("mid_pre_tag", 128'(bus.out_tag), 128'hA5);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_z", 128'(bus.out_z), 128'd0);
        chk("mid_rst_tag", 128'(bus.out_tag), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_in_ready", 128'(bus.in_ready), 128'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_no_stale", 128'(bus.out_valid), 128'd0);
        end

`ifdef MODADDSUB_RANGE_CHECK_EN
        chk("rc_clear", 128'(range_err), 128'd0);
        send(MODE_ADD, Q, pk(1, 1, 1, 1), pk(1, 1, Q, 1), 8'h30);
        chk("rc_set", 128'(range_err), 128'd1);
        send(MODE_ADD, Q, pk(1, 2, 3, 4), pk(4, 3, 2, 1), 8'h31);
        send(MODE_SUB, Q, pk(5, 6, 7, 8), pk(1, 2, 3, 4), 8'h32);
        repeat (2) @(posedge clk);
        #1;
        chk("rc_sticky", 128'(range_err), 128'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rc_reset", 128'(range_err), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("final_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_addsub_pipe.md
# mod_addsub_pipe

Pipelined, multi-lane modular adder/subtractor with valid/ready flow control, parametrised in operand width and lane count. Each accepted beat carries LANES operand pairs, one modulus, one mode bit and a tag. The block returns (x ± y) mod q per lane two cycles later. It sits between the butterfly multiplier outputs and the NTT/INTT coefficient write-back path, replacing fixed 28-bit, add-only combinational reduction.

## Interface
Parameters:
- W, 28: operand and modulus width in bits.
- LANES, 4: independent lanes per beat.
- TAG_W, 8: width of the opaque sideband tag carried alongside the data.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  1  0 = add, 1 = subtract (x − y).
- in_q  in  W  modulus for this beat, shared by all lanes.
- in_x  in  LANES*W  packed operands x; lane i occupies bits [i*W +: W].
- in_y  in  LANES*W  packed operands y, same packing.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_z  out  LANES*W  packed results, each in [0, q).
- out_tag  out  TAG_W  tag of the beat in out_z.
- range_err  out  1  sticky range-violation flag. Present only with MODADDSUB_RANGE_CHECK_EN.

## Operation
- Beat accepted when in_valid && in_ready. mode, q, x, y and tag are captured together. Per-beat q allows mixed-modulus (RNS) streams.
- Stage 1 (per lane, W+1-bit result): add gives s = x + y; subtract gives s = x + (q − y). q − y is W+1 bits. When y = 0, s = x + q and stage 2 reduces it.
- Stage 2: z = (s >= q) ? s − q : s, truncated to W bits. Compare and subtract use W+1 bits, with no wrap before the compare.
- Inputs must satisfy x, y < q and 2 ≤ q < 2^W. Under that contract the outputs are exact. Outside the contract the outputs are undefined but deterministic; there is no X-propagation.
- Lanes are fully independent and share only mode, q, tag and flow control.
- Flow control: one global advance enable, adv = !out_valid || out_ready. in_ready = adv. Both stages shift only when adv = 1.
- Bubbles are not collapsed. An empty stage 1 still costs a cycle.
- Beats are never dropped, duplicated or reordered.
- out_z and out_tag stay stable while out_valid && !out_ready.

## Timing
- Latency is 2 cycles from acceptance to out_valid when unstalled.
- Throughput is 1 beat/cycle when out_ready is held high.
- in_ready is combinational from out_ready and out_valid. No other input-to-output combinational path exists.
- Reset (async assert, sync-to-clk deassert assumed upstream) clears:
  - stage valid bits, so out_valid = 0;
  - all data and tag registers to 0, so out_z = 0 and out_tag = 0;
  - range_err = 0.
  in_ready = 1 out of reset.
- A reset mid-stream discards both in-flight beats. No output follows for them.
- Simultaneous out_ready and in_valid while full: the output beat retires, stage 1 moves to stage 2 and the new beat enters stage 1, all in the same cycle.

## Configuration
- MODADDSUB_RANGE_CHECK_EN defined:
  - Stage 1 additionally evaluates (x >= q) || (y >= q) for any lane of an accepted beat, and (q < 2).
  - Any hit sets range_err on the next edge. It stays set until rst_n.
  - Data results are unaffected.
- Not defined: the range_err port and all check logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package mod_arith_pkg: mode encoding constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1, the default W and a default q constant (268369921 = 2^28 − 2^16 + 1) for benches.
- One sub-module, mod_addsub_lane. It holds the per-lane stage-1 and stage-2 datapath registers and is instantiated LANES times under a generate loop.
- The top level owns the valid bits, the tag pipe, adv, and the range-check logic.

## Test plan
- Add with wrap (W = 28, q = 268369921, LANES = 4): x = 268369920, y = 5 -> out_z = 4 exactly 2 cycles after acceptance; the other lanes with x = 1, y = 2 -> 3.
- Subtract edge cases: x = 3, y = 7 -> 268369917. x = 7, y = 7 -> 0. x = 9, y = 0 -> 9 (the s = x + q path).
- Backpressure: stream 8 beats with tags 0..7, hold out_ready low for cycles 3–6 -> in_ready low while full, out_z/out_tag frozen, all 8 tags emerge in order with no loss.
- Mixed moduli and modes: alternate q = 17 / q = 268369921 and add/sub on every beat at full rate -> each result is reduced by its own q; 1 beat/cycle sustained.
- Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid = 0 and out_z = 0 immediately (asynchronously); after release, in_ready = 1 and no stale beat appears.
- With MODADDSUB_RANGE_CHECK_EN: send one beat with lane 2 y = q -> range_err rises next cycle and stays high through subsequent legal beats until reset.
